// File: rtl/display_pkg.sv
// Shared page/mode encodings and helpers for the HEX display sequencer.
package display_pkg;

  typedef enum logic [1:0] {
    PAGE_PRICES = 2'd0,
    PAGE_TRADES = 2'd1,
    PAGE_STATUS = 2'd2
  } page_t;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_FLASH  = 2'd2,
    MODE_HALT   = 2'd3
  } mode_t;

  localparam int unsigned NUM_PAGES  = 3;
  localparam int unsigned NUM_DIGITS = 6;

  // Bits needed to count 0 .. ticks-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned ticks);
    return (ticks <= 2) ? 1 : $clog2(ticks);
  endfunction

  function automatic page_t next_page(input page_t p);
    if (32'(p) >= NUM_PAGES - 1)
      return PAGE_PRICES;
    return page_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for an active-low pushbutton with a one-cycle press pulse.
module key_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  logic meta, sync, sync_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= key_n;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign press = sync_d & ~sync;

endmodule

// File: rtl/display_page_ctrl.sv
// Chooses the metric page driving the six HEX digits: auto-rotate, manual step, match flash, halt status.
// Optional DISP_SNAPSHOT_EN adds a freeze input that holds pages 0/1 on captured values.
module display_page_ctrl
  import display_pkg::*;
#(
  parameter int unsigned ROTATE_TICKS   = 100000000,
  parameter int unsigned MANUAL_TIMEOUT = 250000000,
  parameter int unsigned FLASH_TICKS    = 100000000,
  parameter int unsigned BLINK_TICKS    = 12500000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    key_n,
`ifdef DISP_SNAPSHOT_EN
  input  logic                    freeze,
`endif
  input  logic [7:0]              buy_price,
  input  logic [7:0]              sell_price,
  input  logic [7:0]              spread_now,
  input  logic [7:0]              trade_count,
  input  logic [1:0]              state,
  input  logic                    halt_signal,
  input  logic                    match_signal,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [1:0]              page,
  output logic [1:0]              mode
);

  localparam int unsigned ROT_W   = cnt_width(ROTATE_TICKS);
  localparam int unsigned IDLE_W  = cnt_width(MANUAL_TIMEOUT);
  localparam int unsigned FLASH_W = cnt_width(FLASH_TICKS);
  localparam int unsigned BLINK_W = cnt_width(BLINK_TICKS);

  localparam logic [ROT_W-1:0]   ROT_LAST   = ROT_W'(ROTATE_TICKS - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(MANUAL_TIMEOUT - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  mode_t                mode_q;
  page_t                page_q;
  logic [ROT_W-1:0]     rot_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [FLASH_W-1:0]   flash_cnt;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_ph;
  logic [7:0]           last_match;
  logic                 press;

  logic [7:0] src_buy, src_sell, src_spread, src_trade;
  logic [4*NUM_DIGITS-1:0] digits_nxt;
  logic [NUM_DIGITS-1:0]   blank_nxt;

  key_edge_sync u_key (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (key_n),
    .press  (press)
  );

`ifdef DISP_SNAPSHOT_EN
  logic       freeze_d;
  logic [7:0] snap_buy, snap_sell, snap_spread, snap_trade;
  logic       use_snap;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      freeze_d    <= 1'b0;
      snap_buy    <= '0;
      snap_sell   <= '0;
      snap_spread <= '0;
      snap_trade  <= '0;
    end else begin
      freeze_d <= freeze;
      if (freeze && !freeze_d) begin
        snap_buy    <= buy_price;
        snap_sell   <= sell_price;
        snap_spread <= spread_now;
        snap_trade  <= trade_count;
      end
    end
  end

  // During the capture cycle the snapshot is still loading, so live values (identical) are shown.
  assign use_snap   = freeze & freeze_d;
  assign src_buy    = use_snap ? snap_buy    : buy_price;
  assign src_sell   = use_snap ? snap_sell   : sell_price;
  assign src_spread = use_snap ? snap_spread : spread_now;
  assign src_trade  = use_snap ? snap_trade  : trade_count;
`else
  assign src_buy    = buy_price;
  assign src_sell   = sell_price;
  assign src_spread = spread_now;
  assign src_trade  = trade_count;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q     <= MODE_AUTO;
      page_q     <= PAGE_PRICES;
      rot_cnt    <= '0;
      idle_cnt   <= '0;
      flash_cnt  <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      last_match <= '0;
    end else begin
      if (match_signal)
        last_match <= sell_price;

      if (halt_signal) begin
        mode_q    <= MODE_HALT;
        page_q    <= PAGE_STATUS;
        rot_cnt   <= '0;
        idle_cnt  <= '0;
        flash_cnt <= '0;
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (mode_q == MODE_HALT) begin
        mode_q <= MODE_AUTO;
        page_q <= PAGE_PRICES;
      end else if (match_signal) begin
        mode_q    <= MODE_FLASH;
        page_q    <= PAGE_TRADES;
        rot_cnt   <= '0;
        idle_cnt  <= '0;
        flash_cnt <= '0;
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else begin
        case (mode_q)
          MODE_AUTO: begin
            if (press) begin
              mode_q   <= MODE_MANUAL;
              page_q   <= next_page(page_q);
              rot_cnt  <= '0;
              idle_cnt <= '0;
            end else if (rot_cnt == ROT_LAST) begin
              rot_cnt <= '0;
              page_q  <= next_page(page_q);
            end else begin
              rot_cnt <= rot_cnt + 1'b1;
            end
          end
          MODE_MANUAL: begin
            if (press) begin
              page_q   <= next_page(page_q);
              idle_cnt <= '0;
            end else if (idle_cnt == IDLE_LAST) begin
              mode_q   <= MODE_AUTO;
              rot_cnt  <= '0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          MODE_FLASH: begin
            if (flash_cnt == FLASH_LAST) begin
              mode_q    <= MODE_AUTO;
              rot_cnt   <= '0;
              flash_cnt <= '0;
              blink_cnt <= '0;
              blink_ph  <= 1'b0;
            end else begin
              flash_cnt <= flash_cnt + 1'b1;
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end
          default: mode_q <= MODE_AUTO;
        endcase
      end
    end
  end

  always_comb begin
    digits_nxt = '0;
    blank_nxt  = '0;
    case (page_q)
      PAGE_PRICES: digits_nxt = {src_spread, src_sell, src_buy};
      PAGE_TRADES: begin
        digits_nxt = {src_trade, 8'h00, last_match};
        blank_nxt  = 6'b001100;
        if (mode_q == MODE_FLASH && blink_ph)
          blank_nxt[5:4] = 2'b11;
      end
      PAGE_STATUS: begin
        digits_nxt = {4'h0, 2'b00, state, 8'h00, 4'h0, 3'b000, halt_signal};
        blank_nxt  = 6'b001100;
      end
      default: blank_nxt = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      digits <= '0;
      blank  <= '1;
    end else begin
      digits <= digits_nxt;
      blank  <= blank_nxt;
    end
  end

  assign page = page_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_display_page_ctrl.sv
// Directed checks of display_page_ctrl with shortened timers; freeze tests need DISP_SNAPSHOT_EN.
module tb_display_page_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        key_n;
  logic [7:0]  buy_price, sell_price, spread_now, trade_count;
  logic [1:0]  state;
  logic        halt_signal, match_signal;
  logic [23:0] digits;
  logic [5:0]  blank;
  logic [1:0]  page, mode;
`ifdef DISP_SNAPSHOT_EN
  logic        freeze;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [5:0]  exp_bl;

  display_page_ctrl #(
    .ROTATE_TICKS   (8),
    .MANUAL_TIMEOUT (20),
    .FLASH_TICKS    (12),
    .BLINK_TICKS    (3)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .key_n        (key_n),
`ifdef DISP_SNAPSHOT_EN
    .freeze       (freeze),
`endif
    .buy_price    (buy_price),
    .sell_price   (sell_price),
    .spread_now   (spread_now),
    .trade_count  (trade_count),
    .state        (state),
    .halt_signal  (halt_signal),
    .match_signal (match_signal),
    .digits       (digits),
    .blank        (blank),
    .page         (page),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; key_n = 1'b1;
    buy_price = 8'h3A; sell_price = 8'h3C; spread_now = 8'h02; trade_count = 8'h07;
    state = 2'd1; halt_signal = 1'b0; match_signal = 1'b0;
`ifdef DISP_SNAPSHOT_EN
    freeze = 1'b0;
`endif
    tick(); tick();
    check("rst_page",   24'(page),  24'd0);
    check("rst_mode",   24'(mode),  24'd0);
    check("rst_digits", digits,     24'h0);
    check("rst_blank",  24'(blank), 24'h3F);

    // Auto rotation
    resetn = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 1) begin
        check("p0_digits", digits, 24'h023C3A);
        check("p0_blank", 24'(blank), 24'h00);
      end
      if (i == 7)  check("rot_pre8", 24'(page), 24'd0);
      if (i == 8)  check("rot_8",    24'(page), 24'd1);
      if (i == 9) begin
        check("p1_digits", digits, 24'h070000);
        check("p1_blank", 24'(blank), 24'h0C);
      end
      if (i == 15) check("rot_pre16", 24'(page), 24'd1);
      if (i == 16) check("rot_16",    24'(page), 24'd2);
      if (i == 17) begin
        check("p2_digits", digits, 24'h010000);
        check("p2_blank", 24'(blank), 24'h0C);
      end
      if (i == 24) begin
        check("rot_24", 24'(page), 24'd0);
        check("rot_mode", 24'(mode), 24'd0);
      end
    end

    // Manual step: held key gives one press on the 3rd edge
    key_n = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      tick();
      if (i == 10) key_n = 1'b1;
      if (i == 2)  check("key_e2_page", 24'(page), 24'd0);
      if (i == 3) begin
        check("key_e3_page", 24'(page), 24'd1);
        check("key_e3_mode", 24'(mode), 24'd1);
      end
      if (i == 10) check("key_hold_page", 24'(page), 24'd1);
      if (i == 22) check("man_idle_mode", 24'(mode), 24'd1);
      if (i == 23) begin
        check("man_to_auto", 24'(mode), 24'd0);
        check("man_keep_pg", 24'(page), 24'd1);
      end
    end

    // Match flash with blink on HEX5:4
    sell_price = 8'h41; match_signal = 1'b1;
    tick();
    match_signal = 1'b0;
    check("fl_mode", 24'(mode), 24'd2);
    check("fl_page", 24'(page), 24'd1);
    for (int f = 1; f <= 13; f++) begin
      tick();
      if (f <= 12) exp_bl = (((f - 1) / 3) % 2 == 1) ? 6'h3C : 6'h0C;
      else         exp_bl = 6'h0C;
      check($sformatf("fl_blank_%0d", f), 24'(blank), 24'(exp_bl));
      if (f == 1)  check("fl_digits", digits, 24'h070041);
      if (f == 11) check("fl_mode_11", 24'(mode), 24'd2);
      if (f == 12) begin
        check("fl_end_mode", 24'(mode), 24'd0);
        check("fl_end_page", 24'(page), 24'd1);
      end
    end

    // Second match at cycle 6 restarts the flash
    match_signal = 1'b1;
    tick();
    match_signal = 1'b0;
    for (int g = 1; g <= 18; g++) begin
      if (g == 6) begin
        sell_price = 8'h55; match_signal = 1'b1;
      end
      tick();
      match_signal = 1'b0;
      if (g == 7)  check("fl2_digits", digits, 24'h070055);
      if (g == 17) check("fl2_mode_17", 24'(mode), 24'd2);
      if (g == 18) check("fl2_mode_18", 24'(mode), 24'd0);
    end

    // Halt overrides flash
    match_signal = 1'b1;
    tick();
    match_signal = 1'b0;
    tick(); tick();
    state = 2'd2; halt_signal = 1'b1;
    tick();
    check("halt_mode", 24'(mode), 24'd3);
    check("halt_page", 24'(page), 24'd2);
    tick();
    check("halt_digits", digits, 24'h020001);
    check("halt_blank", 24'(blank), 24'h0C);
    sell_price = 8'h66; match_signal = 1'b1;
    tick();
    match_signal = 1'b0;
    check("halt_match_mode", 24'(mode), 24'd3);
    halt_signal = 1'b0;
    tick();
    check("unhalt_mode", 24'(mode), 24'd0);
    check("unhalt_page", 24'(page), 24'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 8) check("unhalt_rot", 24'(page), 24'd1);
      if (k == 9) check("halt_lm", digits, 24'h070066);
    end

    // Match and press in the same cycle: match wins
    key_n = 1'b0;
    tick(); tick();
    sell_price = 8'h77; match_signal = 1'b1;
    tick();
    match_signal = 1'b0;
    check("sim_mode", 24'(mode), 24'd2);
    check("sim_page", 24'(page), 24'd1);
    tick(); tick();

    // Reset mid-flash
    resetn = 1'b0; key_n = 1'b1;
    tick();
    check("mrst_blank",  24'(blank), 24'h3F);
    check("mrst_mode",   24'(mode),  24'd0);
    check("mrst_page",   24'(page),  24'd0);
    check("mrst_digits", digits,     24'h0);
    resetn = 1'b1;
    for (int r = 1; r <= 24; r++) begin
      tick();
      if (r == 8)  check("mrst_rot", 24'(page), 24'd1);
      if (r == 9)  check("mrst_lm", digits, 24'h070000);
      if (r == 24) check("mrst_wrap", 24'(page), 24'd0);
    end

`ifdef DISP_SNAPSHOT_EN
    buy_price = 8'h10; freeze = 1'b1;
    tick();
    buy_price = 8'h20;
    tick(); tick();
    check("snap_hold", 24'(digits[7:0]), 24'h10);
    freeze = 1'b0;
    tick();
    check("snap_live", 24'(digits[7:0]), 24'h20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
